voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphony controller that owns NUM_VOICES instances of the sample-index player.
- Accepts note-on/note-off events over a valid/ready handshake.
- Allocates events to voices: retrigger, then free voice, then steal the oldest voice.
- Drives each player's frequency word, its active gate, and a one-cycle restart pulse that resets its sample index. Sits between the MIDI/PS-register event path and the player bank, in the mclk domain.

Parameters:
- NUM_VOICES, 4, number of player voices managed (power of two, 2..16).
- FREQ_RES_BITS, 16, width of the per-voice frequency word passed to each player.
- NOTE_BITS, 7, width of the note identifier used to match note-off to note-on.

Ports:
- mclk  input  1  master clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- ev_valid  input  1  event present.
- ev_ready  output  1  allocator can accept an event this cycle.
- ev_on  input  1  1 = note-on, 0 = note-off.
- ev_note  input  NOTE_BITS  note identifier.
- ev_freq  input  FREQ_RES_BITS  frequency word; used only on note-on.
- voice_active  output  NUM_VOICES  per-voice gate.
- voice_freq  output  NUM_VOICES*FREQ_RES_BITS  frequency word per voice; voice v occupies bits [v*FREQ_RES_BITS +: FREQ_RES_BITS].
- voice_restart  output  NUM_VOICES  one-cycle pulse; player v resets its index.
- steal_pulse  output  1  one-cycle pulse when an active voice was stolen.
- active_count  output  $clog2(NUM_VOICES)+1  number of active voices.

Behaviour:
- Reset values:
  - voice_active = 0, voice_freq = 0, voice_restart = 0, steal_pulse = 0, active_count = 0.
  - All stored notes = 0, all age ranks = 0, FSM = IDLE, ev_ready = 0 while rst is asserted.
- Reset mid-operation discards any captured event. Outputs clear asynchronously.
- FSM states:
  - IDLE: ev_ready = 1. On ev_valid & ev_ready, capture ev_on, ev_note and ev_freq, then go to DECIDE.
  - DECIDE: ev_ready = 0. Compute the target voice and action from the captured event and current state, then go to UPDATE.
  - UPDATE: ev_ready = 0. Apply the action and go to IDLE.
- Timing:
  - One event per 3 cycles maximum.
  - Outputs change on the UPDATE clock edge, 2 cycles after the accept edge.
  - restart and steal pulses are high for exactly the one cycle following UPDATE.
- Note-on decision, in priority order:
  1. An active voice already holds ev_note: retrigger that voice. Update freq and pulse restart; no steal.
  2. Otherwise, take the lowest-index inactive voice.
  3. Otherwise (all voices active), steal the voice with the highest age rank (oldest). steal_pulse = 1.
  - In every case the target voice is set active, its note stored, freq written and restart pulsed.
- Note-off: if an active voice holds ev_note, clear its active bit. voice_freq stays unchanged and no restart is pulsed. If no voice matches, nothing changes and the event is still consumed.
- Duplicate notes: at most one active voice holds any note value; this follows from the retrigger rule.
- Age ranks: each active voice holds a rank of $clog2(NUM_VOICES) bits, and the ranks of active voices always form the permutation 0..active_count-1, where 0 is youngest.
  - Allocating a previously inactive voice: every active voice's rank += 1, and the target gets rank 0.
  - Retriggering or stealing voice v with rank r: active voices with rank < r get += 1, and v gets 0.
  - Releasing voice v with rank r: active voices with rank > r get −= 1.
  - Ranks of inactive voices are don't-care but must be reset to 0.
- active_count is a registered popcount of voice_active, updated in the same cycle as voice_active.
- ev_valid held with ev_ready = 0 is legal. The source holds its payload, and the event is accepted on the next IDLE cycle.

Test Plan:
- Reset, then NUM_VOICES = 4 with note-ons 60/f=100, 62/f=200, 64/f=300 → voices 0, 1, 2 active; voice_freq = 100, 200, 300; three single restart pulses; active_count = 3; ready low exactly 2 cycles after each accept.
- Fill all 4 voices (notes 60, 62, 64, 65), then note-on 67/f=500 → voice 0 (oldest) stolen; steal_pulse and restart[0] for one cycle; freq0 = 500; active_count stays 4.
- Voices as above, then note-on 64/f=333 (retrigger) → voice 2 restarts with freq2 = 333, no steal. A following note-on 69 steals voice 1, now the oldest.
- Note-off 62 with voice 1 active → voice_active[1] = 0, freq1 retained, count decrements. Next note-on 70 → lands on voice 1 (lowest free). Note-off for absent note 99 → no output change, event consumed.
- Hold ev_valid continuously with 5 distinct events → exactly 5 accepts, spaced 3 cycles apart. Check the rank permutation invariant after each UPDATE.
- Assert rst during DECIDE of a note-on → all outputs 0 immediately. The captured event is lost. After release, ev_ready = 1 and the first note-on goes to voice 0.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator
//   Polyphony controller for a bank of NUM_VOICES sample-index players.
//   Note-on/note-off events arrive over a valid/ready handshake. Each event
//   is handled in three cycles (IDLE accept, DECIDE, UPDATE). A note-on goes
//   to the voice already holding the note (retrigger), else to the lowest
//   free voice, else the oldest voice is stolen.
//
// Ports
//   mclk           master clock, posedge
//   rst            asynchronous active-high reset
//   ev_valid/ready event handshake; ev_ready is high only in IDLE
//   ev_on          1 = note-on, 0 = note-off
//   ev_note        note identifier
//   ev_freq        frequency word (note-on only)
//   voice_active   per-voice gate
//   voice_freq     packed per-voice frequency words, voice v at [v*FREQ_RES_BITS +: FREQ_RES_BITS]
//   voice_restart  one-cycle pulse, resets the player's sample index
//   steal_pulse    one-cycle pulse when an active voice was stolen
//   active_count   registered popcount of voice_active
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int FREQ_RES_BITS = 16,
  parameter int NOTE_BITS     = 7
) (
  input  logic                                mclk,
  input  logic                                rst,
  input  logic                                ev_valid,
  output logic                                ev_ready,
  input  logic                                ev_on,
  input  logic [NOTE_BITS-1:0]                ev_note,
  input  logic [FREQ_RES_BITS-1:0]            ev_freq,
  output logic [NUM_VOICES-1:0]               voice_active,
  output logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]               voice_restart,
  output logic                                steal_pulse,
  output logic [$clog2(NUM_VOICES):0]         active_count
);

  localparam int RW = $clog2(NUM_VOICES);
  localparam int CW = RW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECIDE,
    S_UPDATE
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_ALLOC,
    ACT_RETRIG,
    ACT_STEAL,
    ACT_RELEASE
  } action_t;

  state_t state_q, state_d;
  action_t action_q, dec_action;
  logic [RW-1:0] tgt_q, dec_tgt;

  logic                     cap_on;
  logic [NOTE_BITS-1:0]     cap_note;
  logic [FREQ_RES_BITS-1:0] cap_freq;

  logic [NOTE_BITS-1:0]     note_q [NUM_VOICES];
  logic [FREQ_RES_BITS-1:0] freq_q [NUM_VOICES];
  logic [RW-1:0]            rank_q [NUM_VOICES];

  logic [NUM_VOICES-1:0] active_d;
  logic [RW-1:0]         rank_d [NUM_VOICES];
  logic [CW-1:0]         count_d;
  logic [RW-1:0]         tgt_rank;

  logic          match_found, free_found;
  logic [RW-1:0] match_idx, free_idx, old_idx, old_rank;

  logic accept;

  // Ready is forced low while reset is held so no event slips in.
  assign ev_ready = (state_q == S_IDLE) && !rst;
  assign accept   = ev_valid && ev_ready;

  always_comb begin
    voice_freq = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_freq[v*FREQ_RES_BITS +: FREQ_RES_BITS] = freq_q[v];
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_DECIDE;
      S_DECIDE: state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Candidate search: matching active voice, lowest free voice, and the
  // active voice with the largest rank (the oldest when all are active).
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    old_idx     = '0;
    old_rank    = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_active[v] && (note_q[v] == cap_note) && !match_found) begin
        match_found = 1'b1;
        match_idx   = RW'(v);
      end
      if (!voice_active[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RW'(v);
      end
      if (voice_active[v] && (rank_q[v] >= old_rank)) begin
        old_rank = rank_q[v];
        old_idx  = RW'(v);
      end
    end

    dec_action = ACT_NONE;
    dec_tgt    = '0;
    if (cap_on) begin
      if (match_found) begin
        dec_action = ACT_RETRIG;
        dec_tgt    = match_idx;
      end else if (free_found) begin
        dec_action = ACT_ALLOC;
        dec_tgt    = free_idx;
      end else begin
        dec_action = ACT_STEAL;
        dec_tgt    = old_idx;
      end
    end else if (match_found) begin
      dec_action = ACT_RELEASE;
      dec_tgt    = match_idx;
    end
  end

  // Next gate and age ranks for the registered action. Ranks of active
  // voices stay a permutation of 0..count-1 with 0 the youngest.
  always_comb begin
    active_d = voice_active;
    for (int v = 0; v < NUM_VOICES; v++) rank_d[v] = rank_q[v];
    tgt_rank = rank_q[tgt_q];
    case (action_q)
      ACT_ALLOC: begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (voice_active[v]) rank_d[v] = rank_q[v] + RW'(1);
        end
        rank_d[tgt_q]   = '0;
        active_d[tgt_q] = 1'b1;
      end
      ACT_RETRIG, ACT_STEAL: begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (voice_active[v] && (rank_q[v] < tgt_rank)) rank_d[v] = rank_q[v] + RW'(1);
        end
        rank_d[tgt_q]   = '0;
        active_d[tgt_q] = 1'b1;
      end
      ACT_RELEASE: begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (voice_active[v] && (rank_q[v] > tgt_rank)) rank_d[v] = rank_q[v] - RW'(1);
        end
        active_d[tgt_q] = 1'b0;
      end
      default: ;
    endcase

    count_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) count_d = count_d + CW'(active_d[v]);
  end

  // Event capture, decision register and voice state. The pulses default
  // low every cycle so they last exactly one cycle after UPDATE.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cap_on        <= 1'b0;
      cap_note      <= '0;
      cap_freq      <= '0;
      action_q      <= ACT_NONE;
      tgt_q         <= '0;
      voice_active  <= '0;
      voice_restart <= '0;
      steal_pulse   <= 1'b0;
      active_count  <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        freq_q[v] <= '0;
        rank_q[v] <= '0;
      end
    end else begin
      voice_restart <= '0;
      steal_pulse   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cap_on   <= ev_on;
            cap_note <= ev_note;
            cap_freq <= ev_freq;
          end
        end
        S_DECIDE: begin
          action_q <= dec_action;
          tgt_q    <= dec_tgt;
        end
        S_UPDATE: begin
          voice_active <= active_d;
          active_count <= count_d;
          for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= rank_d[v];
          if ((action_q == ACT_ALLOC) || (action_q == ACT_RETRIG) || (action_q == ACT_STEAL)) begin
            note_q[tgt_q]        <= cap_note;
            freq_q[tgt_q]        <= cap_freq;
            voice_restart[tgt_q] <= 1'b1;
          end
          steal_pulse <= (action_q == ACT_STEAL);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (NUM_VOICES = 4). A behavioural
// model predicts each event's outcome when it is accepted; the prediction
// is queued and compared against the DUT after the UPDATE edge.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int FW = 16;
  localparam int NW = 7;

  typedef struct packed {
    logic [NV-1:0]    active;
    logic [NV*FW-1:0] freq;
    logic [NV-1:0]    restart;
    logic             steal;
    logic [2:0]       count;
  } exp_t;

  logic             mclk;
  logic             rst;
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_on;
  logic [NW-1:0]    ev_note;
  logic [FW-1:0]    ev_freq;
  logic [NV-1:0]    voice_active;
  logic [NV*FW-1:0] voice_freq;
  logic [NV-1:0]    voice_restart;
  logic             steal_pulse;
  logic [2:0]       active_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int prev_cyc = 0;

  exp_t exp_q[$];
  logic [NV-1:0] prev_active;

  logic [NV-1:0] m_active;
  logic [NW-1:0] m_note [NV];
  logic [FW-1:0] m_freq [NV];
  int            m_rank [NV];

  voice_allocator #(
    .NUM_VOICES(NV),
    .FREQ_RES_BITS(FW),
    .NOTE_BITS(NW)
  ) dut (
    .mclk(mclk),
    .rst(rst),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_on(ev_on),
    .ev_note(ev_note),
    .ev_freq(ev_freq),
    .voice_active(voice_active),
    .voice_freq(voice_freq),
    .voice_restart(voice_restart),
    .steal_pulse(steal_pulse),
    .active_count(active_count)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: observed no finish, expected finish before 100us");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_active    = '0;
    prev_active = '0;
    for (int v = 0; v < NV; v++) begin
      m_note[v] = '0;
      m_freq[v] = '0;
      m_rank[v] = 0;
    end
  endtask

  // Reference behaviour: retrigger, else lowest free, else steal oldest.
  task automatic modelEvent(input logic on, input logic [NW-1:0] note,
                            input logic [FW-1:0] freq, output exp_t e);
    int match;
    int free_v;
    int tgt;
    int r;
    logic stole;
    e      = '0;
    match  = -1;
    free_v = -1;
    tgt    = 0;
    stole  = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (m_active[v] && (m_note[v] == note) && (match < 0)) match = v;
      if (!m_active[v] && (free_v < 0)) free_v = v;
    end
    if (on) begin
      if (match >= 0) begin
        tgt = match;
        r   = m_rank[tgt];
        for (int v = 0; v < NV; v++) if (m_active[v] && (m_rank[v] < r)) m_rank[v]++;
      end else if (free_v >= 0) begin
        tgt = free_v;
        for (int v = 0; v < NV; v++) if (m_active[v]) m_rank[v]++;
      end else begin
        for (int v = 0; v < NV; v++) if (m_rank[v] == NV - 1) tgt = v;
        stole = 1'b1;
        for (int v = 0; v < NV; v++) if (m_rank[v] < NV - 1) m_rank[v]++;
      end
      m_active[tgt]  = 1'b1;
      m_note[tgt]    = note;
      m_freq[tgt]    = freq;
      m_rank[tgt]    = 0;
      e.restart[tgt] = 1'b1;
    end else if (match >= 0) begin
      r = m_rank[match];
      for (int v = 0; v < NV; v++) if (m_active[v] && (m_rank[v] > r)) m_rank[v]--;
      m_active[match] = 1'b0;
    end
    e.active = m_active;
    e.steal  = stole;
    e.count  = 3'($countones(m_active));
    for (int v = 0; v < NV; v++) e.freq[v*FW +: FW] = m_freq[v];
  endtask

  // Presents an event, waits (bounded) for acceptance and, when push is set,
  // queues the predicted result. Returns 1 ns after the accept edge.
  task automatic applyStimulus(input logic on, input logic [NW-1:0] note,
                               input logic [FW-1:0] freq, input bit hold, input bit push);
    exp_t e;
    bit   got;
    @(negedge mclk);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    ev_freq  = freq;
    got      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ev_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge mclk);
    end
    chk("accept_wait", got, 1'b1);
    if (got) begin
      @(posedge mclk);
      #1;
      prev_cyc   = accept_cyc;
      accept_cyc = cyc;
      if (!hold) ev_valid = 1'b0;
      chk("restart_idle", voice_restart, '0);
      chk("steal_idle", steal_pulse, 1'b0);
      if (push) begin
        modelEvent(on, note, freq, e);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called 1 ns after the accept edge; follows the event through UPDATE.
  task automatic checkOutput();
    exp_t e;
    chk("ready_decide", ev_ready, 1'b0);
    @(posedge mclk);
    #1;
    chk("ready_update", ev_ready, 1'b0);
    chk("active_hold", voice_active, prev_active);
    @(posedge mclk);
    #1;
    chk("ready_back", ev_ready, 1'b1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk("voice_active", voice_active, e.active);
      chk("voice_freq", voice_freq, e.freq);
      chk("voice_restart", voice_restart, e.restart);
      chk("steal_pulse", steal_pulse, e.steal);
      chk("active_count", active_count, e.count);
      for (int v = 0; v < NV; v++) begin
        if (m_active[v]) chk($sformatf("rank%0d", v), dut.rank_q[v], m_rank[v]);
      end
      prev_active = e.active;
    end
  endtask

  task automatic resetDut();
    @(negedge mclk);
    rst = 1'b1;
    #1;
    chk("rst_ready", ev_ready, 1'b0);
    chk("rst_active", voice_active, '0);
    chk("rst_freq", voice_freq, '0);
    chk("rst_count", active_count, '0);
    @(negedge mclk);
    rst = 1'b0;
    modelReset();
    #1;
    chk("ready_after_rst", ev_ready, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_note  = '0;
    ev_freq  = '0;
    modelReset();
    repeat (3) @(posedge mclk);
    #1;
    chk("init_ready", ev_ready, 1'b0);
    chk("init_active", voice_active, '0);
    chk("init_freq", voice_freq, '0);
    chk("init_restart", voice_restart, '0);
    chk("init_steal", steal_pulse, 1'b0);
    chk("init_count", active_count, '0);
    @(negedge mclk);
    rst = 1'b0;
    #1;
    chk("init_ready_release", ev_ready, 1'b1);

    $display("[TB] three note-ons");
    applyStimulus(1'b1, 7'd60, 16'd100, 1'b0, 1'b1); checkOutput();
    applyStimulus(1'b1, 7'd62, 16'd200, 1'b0, 1'b1); checkOutput();
    applyStimulus(1'b1, 7'd64, 16'd300, 1'b0, 1'b1); checkOutput();
    chk("three_active", voice_active, 4'b0111);
    chk("three_count", active_count, 3'd3);

    $display("[TB] fill and steal");
    applyStimulus(1'b1, 7'd65, 16'd400, 1'b0, 1'b1); checkOutput();
    applyStimulus(1'b1, 7'd67, 16'd500, 1'b0, 1'b1); checkOutput();
    chk("steal_v0", {steal_pulse, voice_restart}, 5'b1_0001);
    chk("freq0_500", voice_freq[15:0], 16'd500);

    $display("[TB] retrigger then steal oldest");
    applyStimulus(1'b1, 7'd64, 16'd333, 1'b0, 1'b1); checkOutput();
    chk("retrig_v2", {steal_pulse, voice_restart}, 5'b0_0100);
    applyStimulus(1'b1, 7'd69, 16'd600, 1'b0, 1'b1); checkOutput();
    chk("steal_v1", {steal_pulse, voice_restart}, 5'b1_0010);

    $display("[TB] release and reuse");
    resetDut();
    applyStimulus(1'b1, 7'd60, 16'd100, 1'b0, 1'b1); checkOutput();
    applyStimulus(1'b1, 7'd62, 16'd200, 1'b0, 1'b1); checkOutput();
    applyStimulus(1'b1, 7'd64, 16'd300, 1'b0, 1'b1); checkOutput();
    applyStimulus(1'b1, 7'd65, 16'd400, 1'b0, 1'b1); checkOutput();
    applyStimulus(1'b0, 7'd62, 16'd0, 1'b0, 1'b1); checkOutput();
    chk("off_freq1_kept", voice_freq[31:16], 16'd200);
    applyStimulus(1'b1, 7'd70, 16'd700, 1'b0, 1'b1); checkOutput();
    chk("reuse_v1", voice_restart, 4'b0010);
    applyStimulus(1'b0, 7'd99, 16'd0, 1'b0, 1'b1); checkOutput();

    $display("[TB] back-to-back held valid");
    applyStimulus(1'b0, 7'd60, 16'd0, 1'b1, 1'b1); checkOutput();
    applyStimulus(1'b1, 7'd71, 16'd710, 1'b1, 1'b1);
    chk("spacing1", accept_cyc - prev_cyc, 3); checkOutput();
    applyStimulus(1'b1, 7'd72, 16'd720, 1'b1, 1'b1);
    chk("spacing2", accept_cyc - prev_cyc, 3); checkOutput();
    applyStimulus(1'b0, 7'd64, 16'd0, 1'b1, 1'b1);
    chk("spacing3", accept_cyc - prev_cyc, 3); checkOutput();
    applyStimulus(1'b1, 7'd74, 16'd740, 1'b1, 1'b1);
    chk("spacing4", accept_cyc - prev_cyc, 3); checkOutput();
    ev_valid = 1'b0;

    $display("[TB] reset during decide");
    applyStimulus(1'b1, 7'd80, 16'd800, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_active", voice_active, '0);
    chk("mid_rst_freq", voice_freq, '0);
    chk("mid_rst_count", active_count, '0);
    chk("mid_rst_ready", ev_ready, 1'b0);
    @(negedge mclk);
    rst = 1'b0;
    modelReset();
    #1;
    chk("mid_rst_ready_release", ev_ready, 1'b1);
    applyStimulus(1'b1, 7'd81, 16'd810, 1'b0, 1'b1); checkOutput();
    chk("post_rst_v0", voice_active, 4'b0001);

    @(posedge mclk);
    #1;
    chk("final_restart_low", voice_restart, '0);
    chk("final_steal_low", steal_pulse, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
